// File: rtl/pio_sideset_delay_unit_if.sv
// Bundle between a PIO state machine's fetch/control logic and its
// execute-side sequencer.
//   master : fetch/control side. It drives enable, restart, the instruction,
//            issue/stall and the side-set configuration.
//   slave  : sequencer side. It returns decoded fields, ready, the one-shot
//            side-set write and the delay status.
interface pio_sideset_delay_unit_if #(
    parameter int SS_MAX = 5,
    parameter int DLY_W  = 5
);
    logic              en;
    logic              restart;
    logic [15:0]       instr;
    logic              issue;
    logic              stall;
    logic [2:0]        cfg_ss_count;
    logic              cfg_ss_opt;
    logic              cfg_ss_pindirs;
    logic [2:0]        op;
    logic [2:0]        op1;
    logic [4:0]        op2;
    logic              ready;
    logic              ss_valid;
    logic [SS_MAX-1:0] ss_data;
    logic              ss_is_dir;
    logic              delay_active;
    logic [DLY_W-1:0]  delay_left;

    modport master (
        output en, restart, instr, issue, stall,
               cfg_ss_count, cfg_ss_opt, cfg_ss_pindirs,
        input  op, op1, op2, ready, ss_valid, ss_data, ss_is_dir,
               delay_active, delay_left
    );

    modport slave (
        input  en, restart, instr, issue, stall,
               cfg_ss_count, cfg_ss_opt, cfg_ss_pindirs,
        output op, op1, op2, ready, ss_valid, ss_data, ss_is_dir,
               delay_active, delay_left
    );
endinterface

// File: rtl/pio_sideset_delay_unit.sv
// Execute-side sequencer for one PIO state machine.
// It splits the instruction into opcode, operand, side-set and delay fields
// under the runtime side-set configuration. It emits a registered one-shot
// side-set write at issue. It also runs the stall/post-instruction delay
// tracking that gates the next issue.
// Ports:
//   clk     : single clock
//   resetn  : synchronous active-low reset
//   bus     : pio_sideset_delay_unit_if.slave. The inputs are en, restart,
//             instr, issue, stall and cfg_ss_*. The outputs are op/op1/op2
//             (combinational), ready (state decode), and the registered
//             ss_valid/ss_data/ss_is_dir and delay_active/delay_left.
module pio_sideset_delay_unit #(
    parameter int SS_MAX = 5,
    parameter int DLY_W  = 5
) (
    input  logic                    clk,
    input  logic                    resetn,
    pio_sideset_delay_unit_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_DELAY = 2'd2
    } state_t;

    // Side-set width clamped to the 5-bit field.
    function automatic logic [2:0] clamp_count(input logic [2:0] cnt);
        logic [2:0] res;
        if (cnt > 3'd5) begin
            res = 3'd5;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [DLY_W-1:0]  delay_left_r;
    logic              delay_active_r;
    logic              ss_valid_r;
    logic [SS_MAX-1:0] ss_data_r;
    logic              ss_is_dir_r;

    logic [4:0]        field_s;
    logic [2:0]        n_s;
    logic [2:0]        dbits_s;
    logic [4:0]        dly_s;
    logic              ss_en_s;
    logic [4:0]        ss_raw_s;
    logic              ready_s;
    logic              issue_ok_s;
    logic              ss_write_s;

    assign bus.op  = bus.instr[15:13];
    assign bus.op1 = bus.instr[7:5];
    assign bus.op2 = bus.instr[4:0];

    // Field decode of instr[12:8]. The side-set bits occupy the top of the
    // field and the delay bits occupy the remaining low bits.
    always_comb begin
        field_s  = bus.instr[12:8];
        n_s      = clamp_count(bus.cfg_ss_count);
        dbits_s  = 3'd5 - n_s;
        // The low dbits bits form the delay. The mask has exactly dbits ones.
        dly_s    = field_s & (5'h1F >> n_s);
        if (bus.cfg_ss_opt) begin
            ss_en_s  = field_s[4];
            ss_raw_s = (field_s & 5'h0F) >> dbits_s;
        end else begin
            ss_en_s  = (n_s != 3'd0);
            ss_raw_s = field_s >> dbits_s;
        end
    end

    // Next-state logic. The restart and reset overrides live in the state
    // register.
    always_comb begin
        state_nxt_s = state_r;
        if (!bus.en) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.issue) begin
                        if (bus.stall) begin
                            state_nxt_s = ST_STALL;
                        end else if (dly_s != 5'd0) begin
                            state_nxt_s = ST_DELAY;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_STALL: begin
                    // The counter still holds the delay latched at issue.
                    if (bus.stall) begin
                        state_nxt_s = ST_STALL;
                    end else if (delay_left_r != {DLY_W{1'b0}}) begin
                        state_nxt_s = ST_DELAY;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_DELAY: begin
                    if (delay_left_r == {{(DLY_W-1){1'b0}}, 1'b1}) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DELAY;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Output decode: ready, and the qualified issue and side-set strobes.
    always_comb begin
        ready_s    = bus.en & (state_r == ST_IDLE);
        issue_ok_s = ready_s & bus.issue;
        if (issue_ok_s) begin
            ss_write_s = ss_en_s;
        end else begin
            ss_write_s = 1'b0;
        end
    end

    // State register, with the registered delay_active flag that mirrors
    // the next state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r        <= ST_IDLE;
            delay_active_r <= 1'b0;
        end else if (bus.restart) begin
            state_r        <= ST_IDLE;
            delay_active_r <= 1'b0;
        end else if (bus.en) begin
            state_r        <= state_nxt_s;
            delay_active_r <= (state_nxt_s == ST_DELAY);
        end
    end

    // Delay counter and side-set write registers. Reset clears the side-set
    // value and target. Restart only cancels the strobe.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            delay_left_r <= {DLY_W{1'b0}};
            ss_valid_r   <= 1'b0;
            ss_data_r    <= {SS_MAX{1'b0}};
            ss_is_dir_r  <= 1'b0;
        end else if (bus.restart) begin
            delay_left_r <= {DLY_W{1'b0}};
            ss_valid_r   <= 1'b0;
        end else if (!bus.en) begin
            ss_valid_r   <= 1'b0;
        end else begin
            ss_valid_r <= ss_write_s;
            if (ss_write_s) begin
                // Truncation drops any bits at or above SS_MAX.
                ss_data_r   <= ss_raw_s[SS_MAX-1:0];
                ss_is_dir_r <= bus.cfg_ss_pindirs;
            end
            if (issue_ok_s) begin
                delay_left_r <= DLY_W'(dly_s);
            end else if (state_r == ST_DELAY) begin
                delay_left_r <= delay_left_r - {{(DLY_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.ready        = ready_s;
    assign bus.ss_valid     = ss_valid_r;
    assign bus.ss_data      = ss_data_r;
    assign bus.ss_is_dir    = ss_is_dir_r;
    assign bus.delay_active = delay_active_r;
    assign bus.delay_left   = delay_left_r;

endmodule

// File: tb/tb_pio_sideset_delay_unit.sv
module tb_pio_sideset_delay_unit;
    localparam int SS_MAX = 5;
    localparam int DLY_W  = 5;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Reference model. An instruction is in flight while m_in_stall is set
    // or m_dl is nonzero.
    int m_dl;
    bit m_in_stall;
    bit m_ssv;
    int m_ssd;
    bit m_dir;

    always #5 clk = ~clk;

    pio_sideset_delay_unit_if #(.SS_MAX(SS_MAX), .DLY_W(DLY_W)) bus ();

    pio_sideset_delay_unit #(.SS_MAX(SS_MAX), .DLY_W(DLY_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge, using the inputs as they are now.
    task automatic model_step();
        int f, n, dbits, dly, raw;
        bit ss_en;
        f     = int'(bus.instr[12:8]);
        n     = (int'(bus.cfg_ss_count) > 5) ? 5 : int'(bus.cfg_ss_count);
        dbits = 5 - n;
        dly   = f % (1 << dbits);
        ss_en = bus.cfg_ss_opt ? (f / 16 != 0) : (n != 0);
        raw   = (bus.cfg_ss_opt ? f % 16 : f) / (1 << dbits);
        if (!resetn) begin
            m_dl = 0; m_in_stall = 0; m_ssv = 0; m_ssd = 0; m_dir = 0;
        end else if (bus.restart) begin
            m_dl = 0; m_in_stall = 0; m_ssv = 0;
        end else if (!bus.en) begin
            m_ssv = 0;
        end else begin
            m_ssv = 0;
            if (!m_in_stall && m_dl == 0) begin
                if (bus.issue) begin
                    if (ss_en) begin
                        m_ssv = 1;
                        m_ssd = raw % (1 << SS_MAX);
                        m_dir = bus.cfg_ss_pindirs;
                    end
                    m_dl = dly;
                    m_in_stall = bus.stall;
                end
            end else if (m_in_stall) begin
                if (!bus.stall) m_in_stall = 0;
            end else begin
                m_dl = m_dl - 1;
            end
        end
    endtask

    // Compare every DUT output against the model.
    task automatic compare_all();
        chk("ready", bus.ready, (bus.en && !m_in_stall && m_dl == 0) ? 1 : 0);
        chk("ss_valid", bus.ss_valid, m_ssv);
        chk("ss_data", bus.ss_data, m_ssd);
        chk("ss_is_dir", bus.ss_is_dir, m_dir);
        chk("delay_active", bus.delay_active, (!m_in_stall && m_dl > 0) ? 1 : 0);
        chk("delay_left", bus.delay_left, m_dl);
        chk("op", bus.op, int'(bus.instr) / 8192);
        chk("op1", bus.op1, (int'(bus.instr) / 32) % 8);
        chk("op2", bus.op2, int'(bus.instr) % 32);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        bus.en = 1'b1; bus.restart = 1'b0; bus.instr = 16'h0000;
        bus.issue = 1'b0; bus.stall = 1'b0; bus.cfg_ss_count = 3'd0;
        bus.cfg_ss_opt = 1'b0; bus.cfg_ss_pindirs = 1'b0;
        m_dl = 0; m_in_stall = 0; m_ssv = 0; m_ssd = 0; m_dir = 0;
        resetn = 1'b0;
        @(negedge clk);
        cycle();
        cycle();
        chk("reset_ready", bus.ready, 1);
        chk("reset_delay_left", bus.delay_left, 0);
        resetn = 1'b1;

        // Full delay, no side-set.
        bus.instr = 16'hBF42; bus.issue = 1'b1;
        cycle();
        bus.issue = 1'b0;
        chk("t1_dl_first", bus.delay_left, 31);
        chk("t1_active", bus.delay_active, 1);
        chk("t1_ready_low", bus.ready, 0);
        for (int i = 1; i <= 30; i++) begin
            cycle();
            chk("t1_dl_count", bus.delay_left, 31 - i);
        end
        cycle();
        chk("t1_ready_back", bus.ready, 1);
        chk("t1_active_off", bus.delay_active, 0);

        // Optional side-set.
        bus.cfg_ss_count = 3'd3; bus.cfg_ss_opt = 1'b1;
        bus.instr = 16'hBB3C; bus.issue = 1'b1;
        cycle();
        bus.issue = 1'b0;
        chk("t2_ssv", bus.ss_valid, 1);
        chk("t2_ssd", bus.ss_data, 2);
        chk("t2_dl", bus.delay_left, 3);
        repeat (3) cycle();
        chk("t2_ready", bus.ready, 1);
        bus.instr = 16'hAB3C; bus.issue = 1'b1;
        cycle();
        bus.issue = 1'b0;
        chk("t2_no_ssv", bus.ss_valid, 0);
        chk("t2_dl_again", bus.delay_left, 3);
        chk("t2_ssd_hold", bus.ss_data, 2);
        repeat (3) cycle();

        // Stall, then delay.
        bus.cfg_ss_count = 3'd2; bus.cfg_ss_opt = 1'b0;
        bus.instr = 16'h0D00; bus.issue = 1'b1; bus.stall = 1'b1;
        cycle();
        bus.issue = 1'b0;
        chk("t3_ssv", bus.ss_valid, 1);
        chk("t3_ssd", bus.ss_data, 1);
        chk("t3_stall_ready", bus.ready, 0);
        repeat (3) begin
            cycle();
            chk("t3_no_second_ssv", bus.ss_valid, 0);
            chk("t3_stall_inactive", bus.delay_active, 0);
        end
        bus.stall = 1'b0;
        for (int j = 0; j < 5; j++) begin
            cycle();
            chk("t3_delay_left", bus.delay_left, 5 - j);
            chk("t3_delay_active", bus.delay_active, 1);
        end
        cycle();
        chk("t3_ready", bus.ready, 1);

        // Enable freeze, then restart.
        bus.cfg_ss_count = 3'd0;
        bus.instr = 16'h0A00; bus.issue = 1'b1;
        cycle();
        bus.issue = 1'b0;
        repeat (4) cycle();
        chk("t4_dl6", bus.delay_left, 6);
        bus.en = 1'b0;
        repeat (3) begin
            cycle();
            chk("t4_frozen", bus.delay_left, 6);
        end
        bus.en = 1'b1;
        cycle();
        cycle();
        chk("t4_dl4", bus.delay_left, 4);
        bus.restart = 1'b1;
        cycle();
        bus.restart = 1'b0;
        chk("t4_restart_dl", bus.delay_left, 0);
        chk("t4_restart_ready", bus.ready, 1);
        chk("t4_ssd_kept", bus.ss_data, 1);

        // Clamp, pindirs, back-to-back issue, then reset.
        bus.cfg_ss_count = 3'd7; bus.cfg_ss_pindirs = 1'b1;
        bus.instr = 16'h1600; bus.issue = 1'b1;
        cycle();
        chk("t5_ssd", bus.ss_data, 22);
        chk("t5_dir", bus.ss_is_dir, 1);
        chk("t5_dl0", bus.delay_left, 0);
        chk("t5_ready", bus.ready, 1);
        cycle();
        chk("t5_b2b_ssv", bus.ss_valid, 1);
        bus.issue = 1'b0; bus.instr = 16'h0000; bus.en = 1'b0;
        resetn = 1'b0;
        cycle();
        chk("t5_rst_ssd", bus.ss_data, 0);
        chk("t5_rst_dir", bus.ss_is_dir, 0);
        chk("t5_rst_ssv", bus.ss_valid, 0);
        chk("t5_rst_ready", bus.ready, 0);
        resetn = 1'b1; bus.en = 1'b1;

        // Randomised traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            resetn             = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            bus.restart        = ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0;
            bus.en             = ($urandom_range(0, 99) < 90) ? 1'b1 : 1'b0;
            bus.issue          = $urandom_range(0, 1) == 1;
            bus.stall          = ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0;
            bus.instr          = 16'($urandom);
            bus.cfg_ss_count   = 3'($urandom_range(0, 7));
            bus.cfg_ss_opt     = $urandom_range(0, 1) == 1;
            bus.cfg_ss_pindirs = $urandom_range(0, 1) == 1;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
